// File: rtl/cpu_pkg.sv
// Shared CPU types: fetch FSM states, IF/ID bundle, datapath widths.
// No ports; imported by the fetch stage, its interface and IF/ID register.
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 64;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        FAULT
    } fetch_state_t;

    typedef struct packed {
        logic               valid;
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } ifid_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: ROM address/data, downstream control, IF/ID outputs.
// master = fetch stage; slave = ROM plus decode/hazard logic.
interface fetch_stage_if;
    import cpu_pkg::*;

    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_instr;
    logic               stall;
    logic               flush;
    logic               br_taken;
    logic [ADDR_W-1:0]  br_target;
    logic               if_valid;
    logic [INSTR_W-1:0] if_instr;
    logic [ADDR_W-1:0]  if_pc;

    modport master (
        input  imem_instr, stall, flush, br_taken, br_target,
        output imem_addr, if_valid, if_instr, if_pc
    );

    modport slave (
        output imem_instr, stall, flush, br_taken, br_target,
        input  imem_addr, if_valid, if_instr, if_pc
    );

endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register with hold and bubble controls, async reset.
// Ports: clk, reset, hold, bubble, ifid_i (load value), ifid_o (state).
module ifid_reg
    import cpu_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  hold,
    input  logic  bubble,
    input  ifid_t ifid_i,
    output ifid_t ifid_o
);

    ifid_t ifid_d;
    ifid_t ifid_q;

    // A bubble clears valid/instr but leaves pc as it was.
    always_comb begin
        ifid_d = ifid_q;
        if (bubble) begin
            ifid_d.valid = 1'b0;
            ifid_d.instr = NOP_INSTR;
        end else if (!hold) begin
            ifid_d = ifid_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifid_q <= '0;
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign ifid_o = ifid_q;

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 instruction fetch: PC, next-PC select, IF/ID register, fetch counter.
// Ports: clk, reset, bus (fetch_stage_if.master), fetch_cnt, fault.
// Optional FETCH_FAULT_EN adds a sticky misaligned/out-of-range fault.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int unsigned IMEM_SIZE = 1024,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    fetch_stage_if.master    bus,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic             fault
);

    if (IMEM_SIZE <= 4 || (IMEM_SIZE & (IMEM_SIZE - 1)) != 0) begin : g_bad_imem
        $error("IMEM_SIZE must be a power of two above 4");
    end

    fetch_state_t      state_d, state_q;
    logic [ADDR_W-1:0] pc_d, pc_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic              hold;
    logic              bubble;
    ifid_t             ifid_new;
    ifid_t             ifid_cur;

`ifdef FETCH_FAULT_EN
    logic            fault_d, fault_q;
    logic [ADDR_W:0] pc_last;
    logic            fetch_bad;

    // Extra bit keeps pc+3 from wrapping into range.
    assign pc_last   = {1'b0, pc_q} + (ADDR_W+1)'(3);
    assign fetch_bad = (pc_q[1:0] != 2'b00)
                    || (pc_last >= (ADDR_W+1)'(IMEM_SIZE));
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        hold    = 1'b1;
        bubble  = 1'b0;
`ifdef FETCH_FAULT_EN
        fault_d = fault_q;
`endif
        ifid_new.valid = 1'b1;
        ifid_new.instr = bus.imem_instr;
        ifid_new.pc    = pc_q;

        unique case (state_q)
            BOOT: begin
                state_d = RUN;
                bubble  = 1'b1;
            end
            RUN: begin
                if (bus.br_taken) begin
                    pc_d   = bus.br_target;
                    bubble = 1'b1;
                end else if (bus.flush) begin
                    bubble = 1'b1;
                    if (!bus.stall) begin
                        pc_d = pc_q + ADDR_W'(4);
                    end
                end else if (bus.stall) begin
                    hold = 1'b1;
`ifdef FETCH_FAULT_EN
                end else if (fetch_bad) begin
                    state_d = FAULT;
                    fault_d = 1'b1;
                    bubble  = 1'b1;
`endif
                end else begin
                    hold  = 1'b0;
                    pc_d  = pc_q + ADDR_W'(4);
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef FETCH_FAULT_EN
            FAULT: begin
                bubble = 1'b1;
            end
`endif
            default: begin
                state_d = BOOT;
                bubble  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef FETCH_FAULT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    ifid_reg u_ifid (
        .clk    (clk),
        .reset  (reset),
        .hold   (hold),
        .bubble (bubble),
        .ifid_i (ifid_new),
        .ifid_o (ifid_cur)
    );

    assign bus.imem_addr = pc_q;
    assign bus.if_valid  = ifid_cur.valid;
    assign bus.if_instr  = ifid_cur.instr;
    assign bus.if_pc     = ifid_cur.pc;
    assign fetch_cnt     = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: scoreboard of fetched {pc, instr}.
// Build with FETCH_FAULT_EN to exercise the fault path.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic [31:0] fetch_cnt;
    logic        fault;
    logic [31:0] rom [256];

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;

    int total;
    int bad;

    logic [63:0] m_pc;
    logic [31:0] m_cnt;
    logic        m_boot;
    logic        m_valid;
    logic        m_fault;
    logic        m_new;

    fetch_stage_if bus ();

    assign bus.imem_instr = rom[bus.imem_addr[9:2]];

    fetch_stage #(
        .RESET_PC  (64'h0),
        .IMEM_SIZE (1024),
        .CNT_W     (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .fetch_cnt (fetch_cnt),
        .fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc    = 64'h0;
        m_cnt   = 32'h0;
        m_boot  = 1'b1;
        m_valid = 1'b0;
        m_fault = 1'b0;
        m_new   = 1'b0;
        cur.pc    = 64'h0;
        cur.instr = 32'h0;
        exp_q.delete();
    endtask

    // Drive one cycle of inputs, update the reference, sample #1 after the edge.
    task automatic step(input logic s, input logic f,
                        input logic b, input logic [63:0] t);
        exp_t e;
        bus.stall     = s;
        bus.flush     = f;
        bus.br_taken  = b;
        bus.br_target = t;
        m_new = 1'b0;
        if (m_fault) begin
            m_valid = 1'b0;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (b) begin
            m_pc    = t;
            m_valid = 1'b0;
        end else if (f) begin
            m_valid = 1'b0;
            if (!s) m_pc = m_pc + 64'd4;
        end else if (!s) begin
`ifdef FETCH_FAULT_EN
            if (m_pc[1:0] != 2'b00 || ({1'b0, m_pc} + 65'd3) >= 65'd1024) begin
                m_fault = 1'b1;
                m_valid = 1'b0;
            end else
`endif
            begin
                e.pc    = m_pc;
                e.instr = rom[m_pc[9:2]];
                exp_q.push_back(e);
                m_valid = 1'b1;
                m_pc    = m_pc + 64'd4;
                m_cnt   = m_cnt + 32'd1;
                m_new   = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (m_new) cur = exp_q.pop_front();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.stall = 1'b0; bus.flush = 1'b0;
        bus.br_taken = 1'b0; bus.br_target = 64'h0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        total += 6;
        if (bus.imem_addr !== 64'h0) begin bad++; $display("FAIL rst_addr got %h want 0", bus.imem_addr); end
        if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b want 0", bus.if_valid); end
        if (bus.if_instr !== 32'h0) begin bad++; $display("FAIL rst_instr got %h want 0", bus.if_instr); end
        if (bus.if_pc !== 64'h0) begin bad++; $display("FAIL rst_pc got %h want 0", bus.if_pc); end
        if (fetch_cnt !== 32'h0) begin bad++; $display("FAIL rst_cnt got %0d want 0", fetch_cnt); end
        if (fault !== 1'b0) begin bad++; $display("FAIL rst_fault got %b want 0", fault); end
        do_reset();
    endtask

    task automatic test_sequential();
        do_reset();
        step(0, 0, 0, 64'h0);
        total += 2;
        if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL boot_valid got %b want 0", bus.if_valid); end
        if (bus.imem_addr !== 64'h0) begin bad++; $display("FAIL boot_addr got %h want 0", bus.imem_addr); end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 64'h0);
            total += 3;
            if (bus.if_valid !== 1'b1) begin bad++; $display("FAIL seq_valid[%0d] got %b want 1", i, bus.if_valid); end
            if (bus.if_pc !== 64'(i * 4)) begin bad++; $display("FAIL seq_pc[%0d] got %h want %h", i, bus.if_pc, 64'(i * 4)); end
            if (bus.if_instr !== cur.instr) begin bad++; $display("FAIL seq_instr[%0d] got %h want %h", i, bus.if_instr, cur.instr); end
        end
        total++;
        if (fetch_cnt !== 32'd3) begin bad++; $display("FAIL seq_cnt got %0d want 3", fetch_cnt); end
    endtask

    task automatic test_stall();
        do_reset();
        step(0, 0, 0, 64'h0);
        step(0, 0, 0, 64'h0);
        step(0, 0, 0, 64'h0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 64'h0);
            total += 5;
            if (bus.imem_addr !== 64'h8) begin bad++; $display("FAIL stall_addr[%0d] got %h want 8", i, bus.imem_addr); end
            if (bus.if_pc !== 64'h4) begin bad++; $display("FAIL stall_pc[%0d] got %h want 4", i, bus.if_pc); end
            if (bus.if_instr !== rom[1]) begin bad++; $display("FAIL stall_instr[%0d] got %h want %h", i, bus.if_instr, rom[1]); end
            if (bus.if_valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d] got %b want 1", i, bus.if_valid); end
            if (fetch_cnt !== 32'd2) begin bad++; $display("FAIL stall_cnt[%0d] got %0d want 2", i, fetch_cnt); end
        end
        step(0, 0, 0, 64'h0);
        total += 2;
        if (bus.if_pc !== 64'h8) begin bad++; $display("FAIL unstall_pc got %h want 8", bus.if_pc); end
        if (bus.if_instr !== cur.instr) begin bad++; $display("FAIL unstall_instr got %h want %h", bus.if_instr, cur.instr); end
    endtask

    task automatic test_branch();
        step(0, 0, 0, 64'h0);
        total++;
        if (bus.imem_addr !== 64'h10) begin bad++; $display("FAIL pre_br_addr got %h want 10", bus.imem_addr); end
        step(1, 0, 1, 64'h40);
        total += 2;
        if (bus.imem_addr !== 64'h40) begin bad++; $display("FAIL br_addr got %h want 40", bus.imem_addr); end
        if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL br_valid got %b want 0", bus.if_valid); end
        step(0, 0, 0, 64'h0);
        total += 3;
        if (bus.if_valid !== 1'b1) begin bad++; $display("FAIL br_tgt_valid got %b want 1", bus.if_valid); end
        if (bus.if_pc !== 64'h40) begin bad++; $display("FAIL br_tgt_pc got %h want 40", bus.if_pc); end
        if (bus.if_instr !== rom[16]) begin bad++; $display("FAIL br_tgt_instr got %h want %h", bus.if_instr, rom[16]); end
    endtask

    task automatic test_flush();
        step(0, 0, 1, 64'h20);
        step(0, 1, 0, 64'h0);
        total += 5;
        if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL fl_valid got %b want 0", bus.if_valid); end
        if (bus.if_instr !== 32'h0) begin bad++; $display("FAIL fl_instr got %h want 0", bus.if_instr); end
        if (bus.if_pc !== 64'h40) begin bad++; $display("FAIL fl_pc got %h want 40", bus.if_pc); end
        if (bus.imem_addr !== 64'h24) begin bad++; $display("FAIL fl_addr got %h want 24", bus.imem_addr); end
        if (fetch_cnt !== m_cnt) begin bad++; $display("FAIL fl_cnt got %0d want %0d", fetch_cnt, m_cnt); end
        step(1, 1, 0, 64'h0);
        total += 2;
        if (bus.imem_addr !== 64'h24) begin bad++; $display("FAIL fl_stall_addr got %h want 24", bus.imem_addr); end
        if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL fl_stall_valid got %b want 0", bus.if_valid); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            logic s, f, b;
            s = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 5) == 0);
            b = ($urandom_range(0, 7) == 0);
            step(s, f, b, {54'h0, 8'($urandom_range(0, 200)), 2'b00});
            total += 4;
            if (bus.imem_addr !== m_pc) begin bad++; $display("FAIL b2b_addr[%0d] got %h want %h", i, bus.imem_addr, m_pc); end
            if (bus.if_valid !== m_valid) begin bad++; $display("FAIL b2b_valid[%0d] got %b want %b", i, bus.if_valid, m_valid); end
            if (bus.if_instr !== (m_valid ? cur.instr : 32'h0)) begin bad++; $display("FAIL b2b_instr[%0d] got %h want %h", i, bus.if_instr, m_valid ? cur.instr : 32'h0); end
            if (fetch_cnt !== m_cnt) begin bad++; $display("FAIL b2b_cnt[%0d] got %0d want %0d", i, fetch_cnt, m_cnt); end
            if (m_valid) begin
                total++;
                if (bus.if_pc !== cur.pc) begin bad++; $display("FAIL b2b_pc[%0d] got %h want %h", i, bus.if_pc, cur.pc); end
            end
        end
    endtask

    task automatic test_async_reset();
        step(0, 0, 0, 64'h0);
        bus.br_taken  = 1'b1;
        bus.br_target = 64'h80;
        #3;
        reset = 1'b1;
        #1;
        total += 3;
        if (bus.imem_addr !== 64'h0) begin bad++; $display("FAIL arst_addr got %h want 0", bus.imem_addr); end
        if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got %b want 0", bus.if_valid); end
        if (fetch_cnt !== 32'h0) begin bad++; $display("FAIL arst_cnt got %0d want 0", fetch_cnt); end
        do_reset();
        step(0, 0, 0, 64'h0);
        step(0, 0, 0, 64'h0);
        total += 2;
        if (bus.if_pc !== 64'h0) begin bad++; $display("FAIL arst_first_pc got %h want 0", bus.if_pc); end
        if (bus.if_valid !== 1'b1) begin bad++; $display("FAIL arst_first_valid got %b want 1", bus.if_valid); end
    endtask

    task automatic test_misaligned_target();
        do_reset();
        step(0, 0, 0, 64'h0);
        step(0, 0, 0, 64'h0);
        step(0, 0, 1, 64'h3FE);
        total++;
        if (bus.imem_addr !== 64'h3FE) begin bad++; $display("FAIL mis_addr got %h want 3fe", bus.imem_addr); end
        step(0, 0, 0, 64'h0);
        total += 3;
`ifdef FETCH_FAULT_EN
        if (fault !== 1'b1) begin bad++; $display("FAIL mis_fault got %b want 1", fault); end
        if (bus.imem_addr !== 64'h3FE) begin bad++; $display("FAIL mis_frozen got %h want 3fe", bus.imem_addr); end
        if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL mis_valid got %b want 0", bus.if_valid); end
`else
        if (fault !== 1'b0) begin bad++; $display("FAIL mis_fault got %b want 0", fault); end
        if (bus.if_pc !== 64'h3FE) begin bad++; $display("FAIL mis_pc got %h want 3fe", bus.if_pc); end
        if (bus.if_valid !== 1'b1) begin bad++; $display("FAIL mis_valid got %b want 1", bus.if_valid); end
`endif
        for (int i = 0; i < 10; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), {54'h0, 8'($urandom_range(0, 200)), 2'b00});
            total += 3;
            if (bus.if_valid !== m_valid) begin bad++; $display("FAIL mis_rand_valid[%0d] got %b want %b", i, bus.if_valid, m_valid); end
            if (bus.imem_addr !== m_pc) begin bad++; $display("FAIL mis_rand_addr[%0d] got %h want %h", i, bus.imem_addr, m_pc); end
            if (fault !== m_fault) begin bad++; $display("FAIL mis_rand_fault[%0d] got %b want %b", i, fault, m_fault); end
        end
        do_reset();
        total += 2;
        if (fault !== 1'b0) begin bad++; $display("FAIL mis_clear got %b want 0", fault); end
        if (bus.imem_addr !== 64'h0) begin bad++; $display("FAIL mis_clear_addr got %h want 0", bus.imem_addr); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 256; i++) begin
            rom[i] = 32'h8B00_0001 + 32'(i) * 32'h0001_0103;
        end
        reset = 1'b1;
        bus.stall = 1'b0; bus.flush = 1'b0;
        bus.br_taken = 1'b0; bus.br_target = 64'h0;
        model_reset();
        #1;
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_flush();
        test_back_to_back();
        test_async_reset();
        test_misaligned_target();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the LEGv8 CPU. It directly feeds the instruction ROM's address input and consumes the ROM's 32-bit word.
- Holds the program counter and computes next-PC: sequential, redirect, or hold.
- Registers {pc, instruction, valid} into an IF/ID register consumed by decode.
- Handles stall, flush and branch redirect from downstream, and keeps a retired-fetch counter.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- IMEM_SIZE, 1024, instruction memory size in bytes; power of two, >4.
- CNT_W, 32, width of the fetch counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- stall  in  1  hold PC and IF/ID contents.
- flush  in  1  replace IF/ID contents with a bubble (valid=0).
- br_taken  in  1  redirect fetch to br_target.
- br_target  in  64  redirect byte address.
- imem_addr  out  64  byte address to the instruction ROM; always equals the PC register.
- imem_instr  in  32  combinational ROM read data for imem_addr.
- if_valid  out  1  IF/ID holds a real instruction.
- if_instr  out  32  IF/ID instruction.
- if_pc  out  64  IF/ID instruction address.
- fetch_cnt  out  CNT_W  count of instructions written into IF/ID with valid=1.
- fault  out  1  sticky fetch fault. Present only with FETCH_FAULT_EN; otherwise constant 0.

Behaviour:
- Reset (async, any time, including mid-stall or mid-redirect):
  - pc=RESET_PC, state=BOOT.
  - if_valid=0, if_instr=0, if_pc=0, fetch_cnt=0, fault=0.
- States:
  - BOOT: one cycle, always → RUN. Outputs a bubble; PC unchanged, so the first fetch uses RESET_PC.
  - RUN: normal operation.
  - FAULT: exists only with the macro.
- RUN priority per cycle, highest first:
  1. br_taken: pc←br_target; IF/ID←bubble. This applies regardless of stall and flush, because the wrong-path word is discarded.
  2. flush (without br_taken): IF/ID←bubble; pc←pc+4 unless stall, in which case pc holds.
  3. stall: pc and IF/ID hold, including if_valid.
  4. otherwise: IF/ID←{pc, imem_instr, 1}; pc←pc+4.
- Latency:
  - imem_addr=pc combinationally.
  - The word at address A appears on if_instr one clock after the edge where pc=A is sampled without stall, flush or redirect.
- Arithmetic: pc+4 is 64-bit modular; wrap at 2^64 is not special-cased.
- fetch_cnt increments by 1 only on case 4. It wraps modulo 2^CNT_W.
- br_target is not checked for alignment or range in the base build.
- A bubble sets if_valid=0 and if_instr=0; if_pc keeps its previous value.
- Inputs are sampled only at posedge; there is no combinational path from stall, flush or br_* to the outputs.

Optional Feature:
- Macro: FETCH_FAULT_EN.
- With the macro:
  - In RUN, a fault is detected when a pc about to be fetched (case 4) has pc[1:0]≠0 or pc+3≥IMEM_SIZE.
  - On detection: go to FAULT, set fault=1, insert a bubble, do not increment fetch_cnt.
  - In FAULT: pc frozen, if_valid=0, all inputs ignored, exit only by reset.
  - A br_target that is misaligned or out of range is accepted into pc and faults on its first fetch attempt.
- Without the macro: no FAULT state; fault is tied to 0; out-of-range addresses pass to the ROM unchecked.

Decomposition:
- Shared package cpu_pkg holds:
  - fetch_state_t enum {BOOT, RUN, FAULT}.
  - INSTR_W=32, ADDR_W=64, NOP_INSTR=32'h0.
  - ifid_t struct {valid, instr, pc}.
- One natural sub-module: ifid_reg, the IF/ID pipeline register with hold (stall) and bubble (flush) controls, async reset.
- PC/next-PC logic and the FSM stay in fetch_stage.

Test Plan:
- Reset release, no stall, ROM[0..2]=X0,X1,X2:
  - cycle after BOOT: if_valid=0;
  - then if_pc=0/4/8 with if_instr=X0/X1/X2 on successive cycles;
  - fetch_cnt=3.
- stall held 3 cycles while if_pc=4:
  - imem_addr stays 8; if_pc=4 and if_instr unchanged;
  - fetch_cnt unchanged;
  - after release, next if_pc=8.
- br_taken=1, br_target=0x40 together with stall=1 at pc=0x10:
  - next cycle imem_addr=0x40, if_valid=0;
  - following cycle if_pc=0x40.
- flush=1 alone at pc=0x20:
  - if_valid=0, if_instr=0; pc advances to 0x24;
  - fetch_cnt not incremented.
- Assert reset asynchronously mid-cycle during a redirect:
  - outputs clear before the next edge: imem_addr=RESET_PC, if_valid=0, fetch_cnt=0.
- FETCH_FAULT_EN, br_target=0x3FE:
  - fault=1 one cycle after pc=0x3FE; imem_addr frozen at 0x3FE;
  - if_valid=0 for 10 cycles despite toggling inputs;
  - reset clears fault.
